// File: rtl/serial_bit_source_pkg.sv
// Shared definitions for the serial bit source: FSM state encoding and
// the bit-counter width helper.
package serial_bit_source_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // A one-bit word still needs a one-bit counter.
    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_source_piso_shreg.sv
// WIDTH-bit load/shift register; the head bit is always the MSB, shifting
// toward it, so an empty register naturally drains to a 0 head.
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             head_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = shreg_q << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign head_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// streams them one bit per clock on x, back-to-back with no gap cycles.
module serial_bit_source
    import serial_bit_source_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lastBit;
    logic            accept;
    logic            load;
    logic            shift;
    logic [WIDTH-1:0] loadWord;

    // The register always emits from its MSB, so LSB-first words are mirrored on load.
    always_comb begin
        loadWord = din;
        if (MSB_FIRST == 1'b0) begin
            for (int i = 0; i < WIDTH; i++) begin
                loadWord[i] = din[WIDTH-1-i];
            end
        end
    end

    assign lastBit   = (state_q == S_SHIFT) && (cnt_q == LAST);
    assign din_ready = (state_q == S_IDLE) || (cnt_q == LAST);
    assign accept    = din_valid && din_ready;

    // The final shift of an unreplaced word leaves the register zero, giving idle fill.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q != LAST) begin
                    shift = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end else if (accept) begin
                    load  = 1'b1;
                    cnt_d = '0;
                end else begin
                    shift   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (loadWord),
        .head_o  (x)
    );

    assign x_valid = (state_q == S_SHIFT);
    assign busy    = (state_q == S_SHIFT);
    assign done    = lastBit;

endmodule

// File: tb/tb_serial_bit_source.sv
// Self-checking bench for serial_bit_source: three instances (8-bit MSB-first,
// 8-bit LSB-first, 1-bit) compared every cycle against a bit-queue model.
module tb_serial_bit_source;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dinA = '0;
    logic [7:0] dinB = '0;
    logic       dinC = 1'b0;
    logic [2:0] vld = '0;
    logic [2:0] rdy, xo, xv, bsy, dn;
    logic       started = 1'b0;

    int passCount  = 0;
    int checkCount = 0;

    // Model: each queue holds the bits still owed on x; element 0 is on x now.
    bit qA[$];
    bit qB[$];
    bit qC[$];

    always #5 clk = ~clk;

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) dutA (
        .clk(clk), .rst(rst), .din(dinA), .din_valid(vld[0]), .din_ready(rdy[0]),
        .x(xo[0]), .x_valid(xv[0]), .busy(bsy[0]), .done(dn[0])
    );

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0)) dutB (
        .clk(clk), .rst(rst), .din(dinB), .din_valid(vld[1]), .din_ready(rdy[1]),
        .x(xo[1]), .x_valid(xv[1]), .busy(bsy[1]), .done(dn[1])
    );

    serial_bit_source #(.WIDTH(1), .MSB_FIRST(1'b1)) dutC (
        .clk(clk), .rst(rst), .din(dinC), .din_valid(vld[2]), .din_ready(rdy[2]),
        .x(xo[2]), .x_valid(xv[2]), .busy(bsy[2]), .done(dn[2])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compareInst(input string tag, input logic r, input logic xb, input logic v,
                               input logic b, input logic d, input int sz, input bit hd);
        checkOutput({tag, ".din_ready"}, r,  (sz <= 1));
        checkOutput({tag, ".x"},         xb, hd);
        checkOutput({tag, ".x_valid"},   v,  (sz > 0));
        checkOutput({tag, ".busy"},      b,  (sz > 0));
        checkOutput({tag, ".done"},      d,  (sz == 1));
    endtask

    // Acceptance is decided from the queue depth, then the bit on x is retired.
    always @(posedge clk or posedge rst) begin : modelUpdate
        logic [2:0] acc;
        if (rst) begin
            qA.delete();
            qB.delete();
            qC.delete();
        end else begin
            acc = vld & {(qC.size() <= 1), (qB.size() <= 1), (qA.size() <= 1)};
            if (qA.size() > 0) void'(qA.pop_front());
            if (qB.size() > 0) void'(qB.pop_front());
            if (qC.size() > 0) void'(qC.pop_front());
            if (acc[0]) for (int i = 7; i >= 0; i--) qA.push_back(dinA[i]);
            if (acc[1]) for (int i = 0; i < 8; i++) qB.push_back(dinB[i]);
            if (acc[2]) qC.push_back(dinC);
        end
    end

    always @(negedge clk) begin
        if (started && !rst) begin
            compareInst("A", rdy[0], xo[0], xv[0], bsy[0], dn[0], qA.size(), (qA.size() > 0) ? qA[0] : 1'b0);
            compareInst("B", rdy[1], xo[1], xv[1], bsy[1], dn[1], qB.size(), (qB.size() > 0) ? qB[0] : 1'b0);
            compareInst("C", rdy[2], xo[2], xv[2], bsy[2], dn[2], qC.size(), (qC.size() > 0) ? qC[0] : 1'b0);
        end
    end

    // Presents one word on instance A (and B) for a single accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] which);
        @(negedge clk); #2;
        dinA = a;
        dinB = b;
        vld  = which;
        @(posedge clk); #2;
        vld  = '0;
    endtask

    initial begin : stim
        logic [7:0]  capA, capB, dmask;
        logic [16:0] rhist;
        logic [17:0] dhist;
        logic [9:0]  shist;
        logic [3:0]  capC;
        logic [2:0]  acc;
        logic        rall, dall;
        int          vcount, ones;
        bit          seqC[4];

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset.x",       xo,  3'b000);
        checkOutput("reset.x_valid", xv,  3'b000);
        checkOutput("reset.busy",    bsy, 3'b000);
        checkOutput("reset.done",    dn,  3'b000);
        checkOutput("reset.ready",   rdy, 3'b111);
        rst = 1'b0;
        started = 1'b1;

        // Single word: B0 MSB-first on A, 0D LSB-first on B; both read 1,0,1,1,0,0,0,0.
        applyStimulus(8'hB0, 8'h0D, 3'b011);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            capA[7-i] = xo[0];
            capB[7-i] = xo[1];
            dmask[i]  = dn[0];
        end
        checkOutput("single.msbFirst", capA, 8'hB0);
        checkOutput("single.lsbFirst", capB, 8'hB0);
        checkOutput("single.doneLast", dmask, 8'h80);

        // Back-to-back: B0 then 0B with valid held.
        @(negedge clk); #2;
        dinA = 8'hB0;
        vld[0] = 1'b1;
        vcount = 0;
        dhist = '0;
        for (int c = 0; c <= 16; c++) begin
            rhist[c] = rdy[0];
            @(posedge clk); #2;
            if (c == 0) dinA = 8'h0B;
            if (c == 8) vld[0] = 1'b0;
            @(negedge clk); #1;
            dhist[c+1] = dn[0];
            vcount += int'(xv[0]);
        end
        checkOutput("b2b.readyCycles", rhist, 17'h10101);
        checkOutput("b2b.doneCycles",  dhist, 18'h10100);
        checkOutput("b2b.validCount",  vcount, 16);

        // Stall: FF accepted, 00 offered from cycle 3 but only taken at the end of cycle 8.
        applyStimulus(8'hFF, 8'h00, 3'b001);
        shist = '0;
        ones = 0;
        vcount = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk); #1;
            if (c <= 9) shist[c] = rdy[0];
            ones   += int'(xo[0]);
            vcount += int'(xv[0]);
            #1;
            if (c == 3) begin
                dinA = 8'h00;
                vld[0] = 1'b1;
            end
            if (c == 9) vld[0] = 1'b0;
        end
        checkOutput("stall.readyCycles", shist, 10'h100);
        checkOutput("stall.ones",        ones, 8);
        checkOutput("stall.validCount",  vcount, 16);

        // Reset mid-word: AA, rst raised in cycle 4.
        applyStimulus(8'hAA, 8'h00, 3'b001);
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        checkOutput("rstMid.validBefore", xv[0], 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rstMid.x",       xo[0], 1'b0);
        checkOutput("rstMid.x_valid", xv[0], 1'b0);
        checkOutput("rstMid.done",    dn[0], 1'b0);
        checkOutput("rstMid.ready",   rdy[0], 1'b1);
        @(negedge clk); #2;
        rst = 1'b0;
        applyStimulus(8'h80, 8'h00, 3'b001);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            capA[7-i] = xo[0];
            dmask[i]  = dn[0];
        end
        checkOutput("rstMid.nextWord", capA, 8'h80);
        checkOutput("rstMid.nextDone", dmask, 8'h80);

        // WIDTH=1 stream 1,0,1,1 with valid held.
        seqC = '{1'b1, 1'b0, 1'b1, 1'b1};
        @(negedge clk); #2;
        dinC = seqC[0];
        vld[2] = 1'b1;
        rall = 1'b1;
        dall = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            rall &= rdy[2];
            @(posedge clk); #2;
            if (i < 3) dinC = seqC[i+1];
            else vld[2] = 1'b0;
            @(negedge clk); #1;
            if (i < 4) begin
                capC[3-i] = xo[2];
                dall &= dn[2];
            end
        end
        checkOutput("w1.stream",     capC, 4'b1011);
        checkOutput("w1.readyAlways", rall, 1'b1);
        checkOutput("w1.doneAlways",  dall, 1'b1);

        // Random traffic on all three instances; din held until accepted.
        @(negedge clk); #2;
        for (int n = 0; n < 600; n++) begin
            acc = vld & rdy;
            @(posedge clk); #2;
            if (acc[0] || !vld[0]) begin
                vld[0] = ($urandom_range(0, 3) != 0);
                dinA = 8'($urandom);
            end
            if (acc[1] || !vld[1]) begin
                vld[1] = ($urandom_range(0, 3) != 0);
                dinB = 8'($urandom);
            end
            if (acc[2] || !vld[2]) begin
                vld[2] = ($urandom_range(0, 2) != 0);
                dinC = 1'($urandom);
            end
            @(negedge clk); #2;
        end
        vld = '0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parallel-to-serial front end for the single-bit sequence detector stage. It accepts WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per clock on `x`, which drives the detector's serial input directly. Back-to-back words are streamed with no gap cycles. While idle, the block drives a defined 0 level so the detector relaxes to its start state.

## Interface
- `WIDTH`, default 8: word length in bits; legal values are ≥1.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  WIDTH  parallel word to send.
- `din_valid`  in  1  `din` holds a word to send.
- `din_ready`  out  1  the block accepts `din` on this edge.
- `x`  out  1  serial bit; connects to the detector input.
- `x_valid`  out  1  `x` carries a word bit, not idle fill.
- `busy`  out  1  a word is being shifted.
- `done`  out  1  one-cycle pulse while the last bit of a word is on `x`.

## Operation
- **States.**
  - S_IDLE: nothing is being sent.
  - S_SHIFT: a word is being sent. Bit counter `cnt`, width max(1,$clog2(WIDTH)), runs from 0 to WIDTH-1.
- **Accept rule.** A word is accepted on an edge where `din_valid && din_ready`.
- **`din_ready`** is combinational:
  - 1 in S_IDLE.
  - 1 in S_SHIFT when cnt==WIDTH-1.
  - 0 otherwise.
- **S_IDLE transitions.**
  - Accept → load the shift register with `din` (bit-reversed when MSB_FIRST=0), cnt←0, go to S_SHIFT.
  - No accept → stay. x=0, x_valid=0.
- **S_SHIFT, cnt<WIDTH-1.** Shift one position, cnt←cnt+1.
- **S_SHIFT, cnt==WIDTH-1.**
  - Accept → reload, cnt←0, stay in S_SHIFT. This is the seamless back-to-back case.
  - No accept → go to S_IDLE.
- **Outputs are registered.**
  - `x` is the current head bit of the shift register.
  - x_valid = busy = (state==S_SHIFT).
  - done = (state==S_SHIFT && cnt==WIDTH-1).
- **`din_valid` while `din_ready`=0** is ignored. The upstream must hold `din` stable until it is accepted.
- **WIDTH=1.** Every S_SHIFT cycle is a last cycle, so `din_ready` is always 1.
- **Reset values:** state=S_IDLE, cnt=0, shift register=0, x=0, x_valid=0, busy=0, done=0, `din_ready`=1.

## Timing
- Latency: the first bit appears on `x` in the cycle after the accept edge.
- A word occupies exactly WIDTH consecutive cycles on `x`.
- Throughput: one bit per clock. Continuous words when `din_valid` is held high.
- `done` coincides with the last bit. The detector's Mealy output for that bit is valid in the same cycle.
- **Reset mid-word:** the word is dropped immediately (asynchronously).
  - `x` goes to 0 and `x_valid` goes to 0.
  - No `done` is emitted.
  - The detector is reset on the same `rst`.
- The first accept is possible on the first rising edge after `rst` deasserts.

## Structure
- Shared package/header holds:
  - state encodings S_IDLE=1'b0 and S_SHIFT=1'b1.
  - the counter-width function.
- One natural sub-module: `piso_shreg`, a WIDTH-bit load/shift register with `load` and `shift` enables and a head-bit output.
- `serial_bit_source` itself holds the FSM, the counter and the handshake logic.

## Test plan
- **MSB-first single word.** WIDTH=8, din=8'hB0, one-cycle valid.
  - `x` = 1,0,1,1,0,0,0,0 in cycles 1–8.
  - `done` is high in cycle 8 only.
  - Downstream detector `y`=1 in cycle 4.
- **Back-to-back.** Words 8'hB0 then 8'h0B, `din_valid` held high.
  - 16 contiguous `x_valid` cycles.
  - `din_ready` high in cycles 0, 8 and 16.
  - `done` high in cycles 8 and 16.
- **Stall upstream.** Word 8'hFF accepted, then 8'h00 presented in cycle 3.
  - 8'h00 is not accepted until cycle 8.
  - No bits are lost or duplicated.
- **LSB-first.** MSB_FIRST=0, din=8'h0D.
  - `x` = 1,0,1,1,0,0,0,0.
- **Reset mid-word.** Assert `rst` in cycle 4 of 8'hAA.
  - `x`/`x_valid`/`done` go to 0 immediately.
  - After release, a new word 8'h80 shifts out cleanly: 1 then seven 0s.
- **WIDTH=1.** Stream 1,0,1,1 with `din_valid` held high.
  - `din_ready` is constantly 1.
  - `done` is high every cycle.
  - Detector `y` fires on the fourth bit.
